// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer:
// FSM state encodings and the legal range of the parallel word width.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer_bit_counter.sv
// Frame bit counter. It is cleared at the start of each frame and advanced
// once for each accepted serial bit. The owner clears it on the completing
// bit, so it never counts past N-1.
module bit_counter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [$clog2(N)-1:0] count
);

    localparam int CW = $clog2(N);

    // Clear has priority over increment; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule : bit_counter

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer. A start pulse opens a frame. Bits
// are then collected on din_en strobes, with gaps of any length allowed.
// After WIDTH bits the assembled word is published on dout, with a
// one-cycle dout_valid pulse. All outputs are registered.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] dout_reg;
    logic             valid_reg;
    logic [CW-1:0]    count;

    logic shift_en;
    logic last_bit;
    logic cnt_clr;

    // start always wins over sampling, so a bit is accepted only in SHIFT
    // without start. A bit accepted while the counter reads WIDTH-1 is the
    // last bit of the frame.
    assign shift_en = (state_reg == SHIFT) && din_en && !start;
    assign last_bit = shift_en && (count == CW'(WIDTH - 1));
    assign cnt_clr  = start || last_bit;

    // Shifted word including the incoming bit. The direction is fixed at
    // elaboration: MSB-first shifts left with the new bit at [0], and
    // LSB-first shifts right with the new bit at [WIDTH-1].
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shift_next[gi] = din;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shift_next[gi] = din;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    bit_counter #(
        .N(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (shift_en),
        .count(count)
    );

    // Frame FSM together with the shift register and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            dout_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= SHIFT;
                        shift_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Restart: drop the partial word and stay in SHIFT.
                        shift_reg <= '0;
                    end else if (din_en) begin
                        shift_reg <= shift_next;
                        if (last_bit) begin
                            dout_reg  <= shift_next;
                            valid_reg <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
    assign busy       = (state_reg == SHIFT);

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed testbench for sipo_deserializer. It runs an MSB-first instance
// and an LSB-first instance side by side on the same serial stimulus.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_en;
    logic       start;
    logic [7:0] dout_m;
    logic [7:0] dout_l;
    logic       valid_m;
    logic       valid_l;
    logic       busy_m;
    logic       busy_l;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .start(start),
        .dout(dout_m), .dout_valid(valid_m), .busy(busy_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .start(start),
        .dout(dout_l), .dout_valid(valid_l), .busy(busy_l)
    );

    typedef struct {
        logic       start;
        logic       din_en;
        logic       din;
        logic       exp_valid;
        logic       exp_busy;
        logic [7:0] exp_dout_m;
        logic [7:0] exp_dout_l;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across a rising edge, then settle past the edge.
    task automatic step(input logic s, input logic e, input logic d);
        start  = s;
        din_en = e;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic b,
                           input logic [7:0] dm, input logic [7:0] dl);
        chk({tag, " valid_msb"}, 32'(valid_m), 32'(v));
        chk({tag, " valid_lsb"}, 32'(valid_l), 32'(v));
        chk({tag, " busy_msb"},  32'(busy_m),  32'(b));
        chk({tag, " busy_lsb"},  32'(busy_l),  32'(b));
        chk({tag, " dout_msb"},  32'(dout_m),  32'(dm));
        chk({tag, " dout_lsb"},  32'(dout_l),  32'(dl));
    endtask

    // Send one full frame MSB-first (bit 7 first), with no gaps.
    task automatic send_frame(input logic [7:0] w, input string tag,
                              input logic [7:0] prev_m, input logic [7:0] prev_l);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i]);
            if (i != 0) chk_all(tag, 1'b0, 1'b1, prev_m, prev_l);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int t1;
        int t2;

        // Frame 1,0,1,1,0,0,1,0 followed by one idle cycle.
        pat = 8'hB2;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            vecs[i+1] = '{1'b0, 1'b1, pat[7-i], (i == 7), (i != 7),
                          (i == 7) ? 8'hB2 : 8'h00, (i == 7) ? 8'h4D : 8'h00};
        end
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D};

        // Reset state, observed while rst is held.
        rst = 1'b1; din = 1'b0; din_en = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        // IDLE ignores din_en when there is no start.
        step(1'b0, 1'b1, 1'b1);
        chk_all("idle_ignore", 1'b0, 1'b0, 8'h00, 8'h00);

        // Table-driven: basic frame, including the one-cycle valid check.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].start, vecs[i].din_en, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_busy,
                    vecs[i].exp_dout_m, vecs[i].exp_dout_l);
        end
        $display("txn basic frame: dout_msb=%0h dout_lsb=%0h", dout_m, dout_l);

        // Same bits with 3-cycle din_en gaps. busy stays high, and valid never comes early.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, pat[i]);
            if (i != 0) begin
                chk_all("gap_bit", 1'b0, 1'b1, 8'hB2, 8'h4D);
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, ~pat[i]);
                    chk_all("gap_idle", 1'b0, 1'b1, 8'hB2, 8'h4D);
                end
            end
        end
        chk_all("gap_done", 1'b1, 1'b0, 8'hB2, 8'h4D);
        $display("txn gapped frame: dout_msb=%0h dout_lsb=%0h", dout_m, dout_l);

        // Restart after 5 bits. start also wins over a concurrent din_en.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, i[0]);
            chk_all("partial", 1'b0, 1'b1, 8'hB2, 8'h4D);
        end
        step(1'b1, 1'b1, 1'b0);
        chk_all("restart", 1'b0, 1'b1, 8'hB2, 8'h4D);
        send_frame(8'hFF, "ff_frame", 8'hB2, 8'h4D);
        chk_all("ff_done", 1'b1, 1'b0, 8'hFF, 8'hFF);
        step(1'b0, 1'b0, 1'b0);
        chk_all("ff_after", 1'b0, 1'b0, 8'hFF, 8'hFF);
        $display("txn restart frame: dout_msb=%0h dout_lsb=%0h", dout_m, dout_l);

        // Asynchronous reset between edges, after 4 bits.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 8'h00, 8'h00);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst", 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, "3c_frame", 8'h00, 8'h00);
        chk_all("3c_done", 1'b1, 1'b0, 8'h3C, 8'h3C);
        $display("txn post-reset frame: dout_msb=%0h dout_lsb=%0h", dout_m, dout_l);

        // Back-to-back: start is raised in the dout_valid cycle.
        step(1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, "a5_frame", 8'h3C, 8'h3C);
        chk_all("a5_done", 1'b1, 1'b0, 8'hA5, 8'hA5);
        t1 = cyc;
        step(1'b1, 1'b0, 1'b0);
        chk_all("b2b_start", 1'b0, 1'b1, 8'hA5, 8'hA5);
        send_frame(8'h5A, "5a_frame", 8'hA5, 8'hA5);
        chk_all("5a_done", 1'b1, 1'b0, 8'h5A, 8'h5A);
        t2 = cyc;
        chk("b2b_spacing", 32'(t2 - t1), 32'd9);
        step(1'b0, 1'b0, 1'b0);
        chk_all("5a_after", 1'b0, 1'b0, 8'h5A, 8'h5A);
        $display("txn back-to-back: spacing=%0d dout_msb=%0h", t2 - t1, dout_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sipo_deserializer
